// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int         SHA256_WORD_W  = 32;
  localparam int         SHA256_BLOCK_W = 512;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    PAD_FILL,
    PAD_EMIT,
    PAD_EXTRA
  } pad_state_e;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a big-endian word to its valid bytes and optionally places the 0x80 pad byte right after them.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] data,
  input  logic [2:0]               nbytes,
  input  logic                     insert80,
  output logic [SHA256_WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes)
        word[31-8*b -: 8] = data[31-8*b -: 8];
      else if (insert80 && (3'(b) == nbytes))
        word[31-8*b -: 8] = SHA256_PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha256_message_padder.sv
// Packs a 32-bit word stream into 512-bit blocks and appends SHA-256 padding and bit length.
module sha256_message_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHA256_WORD_W-1:0]  in_data,
  input  logic [2:0]                in_nbytes,
  input  logic                      in_last,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [SHA256_BLOCK_W-1:0] block_out,
  output logic                      block_last,
  output logic                      proto_err
);

  pad_state_e               state, state_nx;
  logic [3:0]               idx, idx_nx;
  logic [LEN_W-1:0]         len, len_nx, len_add, len_inc;
  logic [SHA256_WORD_W-1:0] words    [16];
  logic [SHA256_WORD_W-1:0] words_nx [16];
  logic                     block_last_nx;
  logic                     pend_extra, pend_extra_nx;
  logic                     pend_80, pend_80_nx;
  logic                     proto_err_nx;
  logic                     ready_en;
  logic                     accept, err;
  logic [2:0]               nb_eff;
  logic [SHA256_WORD_W-1:0] pad_w;
  logic [4:0]               p;
  logic [63:0]              len64_inc, len64_cur;

  function automatic logic [63:0] len_to_64(input logic [LEN_W-1:0] l);
    len_to_64 = '0;
    len_to_64[LEN_W-1:0] = l;
  endfunction

  assign in_ready    = ready_en && (state == PAD_FILL);
  assign block_valid = (state == PAD_EMIT);
  assign accept      = in_valid && in_ready;

  // Malformed byte counts are still consumed, as a full 4-byte word.
  assign err     = (in_nbytes > 3'd4) || (!in_last && (in_nbytes != 3'd4));
  assign nb_eff  = err ? 3'd4 : in_nbytes;
  assign len_add = {{(LEN_W-6){1'b0}}, nb_eff, 3'b000};
  assign len_inc = len + len_add;
  assign len64_inc = len_to_64(len_inc);
  assign len64_cur = len_to_64(len);
  // p: word index that receives the 0x80 byte (16 means it spills into an extra block).
  assign p = {1'b0, idx} + {4'd0, (nb_eff == 3'd4)};

  sha256_pad_word u_pad_word (
    .data     (in_data),
    .nbytes   (nb_eff),
    .insert80 (in_last && (nb_eff != 3'd4)),
    .word     (pad_w)
  );

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    len_nx        = len;
    words_nx      = words;
    block_last_nx = block_last;
    pend_extra_nx = pend_extra;
    pend_80_nx    = pend_80;
    proto_err_nx  = 1'b0;
    case (state)
      PAD_FILL: begin
        if (accept) begin
          proto_err_nx = err;
          len_nx       = len_inc;
          idx_nx       = idx + 4'd1;
          for (int j = 0; j < 16; j++)
            if (4'(j) == idx) words_nx[j] = pad_w;
          if (in_last) begin
            for (int j = 0; j < 16; j++) begin
              if ((5'(j) == p) && (nb_eff == 3'd4))
                words_nx[j] = {SHA256_PAD_BYTE, 24'h0};
              else if (5'(j) > p)
                words_nx[j] = '0;
            end
            if (p <= 5'd13) begin
              words_nx[14]  = len64_inc[63:32];
              words_nx[15]  = len64_inc[31:0];
              block_last_nx = 1'b1;
              pend_extra_nx = 1'b0;
              pend_80_nx    = 1'b0;
            end else begin
              block_last_nx = 1'b0;
              pend_extra_nx = 1'b1;
              pend_80_nx    = (p == 5'd16);
            end
            state_nx = PAD_EMIT;
          end else if (idx == 4'd15) begin
            block_last_nx = 1'b0;
            pend_extra_nx = 1'b0;
            state_nx      = PAD_EMIT;
          end
        end
      end
      PAD_EMIT: begin
        if (block_ready) begin
          if (pend_extra) begin
            state_nx = PAD_EXTRA;
          end else begin
            state_nx      = PAD_FILL;
            idx_nx        = 4'd0;
            block_last_nx = 1'b0;
            if (block_last) len_nx = '0;
          end
        end
      end
      PAD_EXTRA: begin
        words_nx[0] = pend_80 ? {SHA256_PAD_BYTE, 24'h0} : '0;
        for (int j = 1; j < 14; j++) words_nx[j] = '0;
        words_nx[14]  = len64_cur[63:32];
        words_nx[15]  = len64_cur[31:0];
        block_last_nx = 1'b1;
        pend_extra_nx = 1'b0;
        pend_80_nx    = 1'b0;
        state_nx      = PAD_EMIT;
      end
      default: state_nx = PAD_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PAD_FILL;
      idx        <= '0;
      len        <= '0;
      block_last <= 1'b0;
      pend_extra <= 1'b0;
      pend_80    <= 1'b0;
      proto_err  <= 1'b0;
      ready_en   <= 1'b0;
      for (int j = 0; j < 16; j++) words[j] <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      len        <= len_nx;
      block_last <= block_last_nx;
      pend_extra <= pend_extra_nx;
      pend_80    <= pend_80_nx;
      proto_err  <= proto_err_nx;
      ready_en   <= 1'b1;
      words      <= words_nx;
    end
  end

  always_comb begin
    block_out = '0;
    for (int j = 0; j < 16; j++) block_out[511-32*j -: 32] = words[j];
  end

endmodule
